// File: rtl/lock_manager_mc.sv
// Multi-channel ownership lock manager.
// Each channel is held by one ID and can release itself after a hold timeout.
module lock_manager_mc #(
  parameter int NUM_CH  = 4,
  parameter int ID_W    = 3,
  parameter int TIMEOUT = 16,
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        lock_req,
  input  logic [NUM_CH-1:0]        unlock,
  input  logic [NUM_CH*ID_W-1:0]   req_id,
  output logic [NUM_CH-1:0]        locked,
  output logic [NUM_CH*ID_W-1:0]   owner,
  output logic [NUM_CH-1:0]        grant,
  output logic [NUM_CH-1:0]        deny,
  output logic [NUM_CH-1:0]        timeout_evt,
  output logic                     any_locked
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t           state   [NUM_CH];
  state_t           state_n [NUM_CH];
  logic [CNT_W-1:0] cnt     [NUM_CH];
  logic [CNT_W-1:0] cnt_n   [NUM_CH];

  logic [NUM_CH*ID_W-1:0] owner_n;
  logic [NUM_CH-1:0]      locked_n;
  logic [NUM_CH-1:0]      grant_n;
  logic [NUM_CH-1:0]      deny_n;
  logic [NUM_CH-1:0]      tevt_n;

  always_comb begin
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] cnt_adv;
    logic             match;
    logic             expire;
    logic             rel;
    logic             refresh;
    owner_n  = owner;
    locked_n = '0;
    grant_n  = '0;
    deny_n   = '0;
    tevt_n   = '0;
    id       = '0;
    cnt_adv  = '0;
    match    = 1'b0;
    expire   = 1'b0;
    rel      = 1'b0;
    refresh  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_n[i] = state[i];
      cnt_n[i]   = cnt[i];
      id      = req_id[i*ID_W +: ID_W];
      match   = (id == owner[i*ID_W +: ID_W]);
      rel     = unlock[i] & match;
      refresh = lock_req[i] & ~unlock[i] & match;
      expire  = 1'b0;
      cnt_adv = '0;
      // A disabled timeout pins the counter at zero.
      if (TIMEOUT > 0) begin
        if (cnt[i] == CNT_W'(TIMEOUT - 1))
          expire = 1'b1;
        else
          cnt_adv = cnt[i] + 1'b1;
      end
      unique case (state[i])
        UNLOCKED: begin
          if (lock_req[i]) begin
            state_n[i] = LOCKED;
            owner_n[i*ID_W +: ID_W] = id;
            cnt_n[i]   = '0;
            grant_n[i] = 1'b1;
          end else if (unlock[i]) begin
            deny_n[i] = 1'b1;
          end
        end
        LOCKED: begin
          unique case (1'b1)
            rel: begin
              state_n[i] = UNLOCKED;
              owner_n[i*ID_W +: ID_W] = '0;
              cnt_n[i]   = '0;
            end
            refresh: begin
              cnt_n[i]   = '0;
              grant_n[i] = 1'b1;
            end
            default: begin
              deny_n[i] = lock_req[i] | unlock[i];
              if (expire) begin
                state_n[i] = UNLOCKED;
                owner_n[i*ID_W +: ID_W] = '0;
                cnt_n[i]  = '0;
                tevt_n[i] = 1'b1;
              end else begin
                cnt_n[i] = cnt_adv;
              end
            end
          endcase
        end
        default: ;
      endcase
      locked_n[i] = (state_n[i] == LOCKED);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= UNLOCKED;
        cnt[i]   <= '0;
      end
      locked      <= '0;
      owner       <= '0;
      grant       <= '0;
      deny        <= '0;
      timeout_evt <= '0;
      any_locked  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= state_n[i];
        cnt[i]   <= cnt_n[i];
      end
      locked      <= locked_n;
      owner       <= owner_n;
      grant       <= grant_n;
      deny        <= deny_n;
      timeout_evt <= tevt_n;
      any_locked  <= |locked_n;
    end
  end

endmodule

// File: tb/tb_lock_manager_mc.sv
// Scoreboard bench for lock_manager_mc.
// Expected outputs are queued at drive time and popped after each edge.
module tb_lock_manager_mc;

  localparam int NC  = 4;
  localparam int IW  = 3;
  localparam int TMO = 16;

  logic            clk;
  logic            rst;
  logic [NC-1:0]   lock_req;
  logic [NC-1:0]   unlock;
  logic [NC*IW-1:0] req_id;
  logic [NC-1:0]   locked;
  logic [NC*IW-1:0] owner;
  logic [NC-1:0]   grant;
  logic [NC-1:0]   deny;
  logic [NC-1:0]   timeout_evt;
  logic            any_locked;

  lock_manager_mc #(
    .NUM_CH (NC),
    .ID_W   (IW),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lock_req   (lock_req),
    .unlock     (unlock),
    .req_id     (req_id),
    .locked     (locked),
    .owner      (owner),
    .grant      (grant),
    .deny       (deny),
    .timeout_evt(timeout_evt),
    .any_locked (any_locked)
  );

  typedef struct {
    logic [NC-1:0]    lk;
    logic [NC*IW-1:0] own;
    logic [NC-1:0]    g;
    logic [NC-1:0]    d;
    logic [NC-1:0]    t;
    logic             any;
  } exp_t;

  exp_t q[$];

  int m_lk  [NC];
  int m_own [NC];
  int m_cnt [NC];
  int n_vec;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      m_lk[c]  = 0;
      m_own[c] = 0;
      m_cnt[c] = 0;
    end
  endtask

  task automatic predict();
    exp_t e;
    e.lk = '0; e.own = '0; e.g = '0; e.d = '0; e.t = '0; e.any = 1'b0;
    if (!rst) begin
      model_clear();
    end else begin
      for (int c = 0; c < NC; c++) begin
        int id;
        id = int'((req_id >> (IW * c)) & 12'h7);
        if (m_lk[c] == 0) begin
          if (lock_req[c]) begin
            m_lk[c] = 1; m_own[c] = id; m_cnt[c] = 0; e.g[c] = 1'b1;
          end else if (unlock[c]) begin
            e.d[c] = 1'b1;
          end
        end else if (unlock[c] && id == m_own[c]) begin
          m_lk[c] = 0; m_own[c] = 0; m_cnt[c] = 0;
        end else if (lock_req[c] && !unlock[c] && id == m_own[c]) begin
          m_cnt[c] = 0; e.g[c] = 1'b1;
        end else begin
          e.d[c] = lock_req[c] | unlock[c];
          m_cnt[c]++;
          if (m_cnt[c] == TMO) begin
            m_lk[c] = 0; m_own[c] = 0; m_cnt[c] = 0; e.t[c] = 1'b1;
          end
        end
      end
    end
    for (int c = 0; c < NC; c++) begin
      e.lk[c] = (m_lk[c] != 0);
      e.own[c*IW +: IW] = m_own[c][IW-1:0];
    end
    e.any = |e.lk;
    q.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    check({tag, "_locked"}, 32'(locked), 32'(e.lk));
    check({tag, "_owner"}, 32'(owner), 32'(e.own));
    check({tag, "_grant"}, 32'(grant), 32'(e.g));
    check({tag, "_deny"}, 32'(deny), 32'(e.d));
    check({tag, "_tevt"}, 32'(timeout_evt), 32'(e.t));
    check({tag, "_any"}, 32'(any_locked), 32'(e.any));
  endtask

  task automatic step(input string tag, input logic [NC-1:0] lr,
                      input logic [NC-1:0] ul, input logic [NC*IW-1:0] ids);
    @(negedge clk);
    lock_req = lr;
    unlock   = ul;
    req_id   = ids;
    predict();
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, '0, '0, '0);
  endtask

  function automatic logic [NC*IW-1:0] id_at(input int ch, input int id);
    logic [NC*IW-1:0] v;
    v = '0;
    v[ch*IW +: IW] = id[IW-1:0];
    return v;
  endfunction

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    lock_req = '1;
    unlock = '0;
    req_id = '0;
    model_clear();

    for (int k = 0; k < 3; k++) step("rst_hold", 4'hF, 4'h0, '0);
    rst = 1'b1;
    step("rst_rel", 4'hF, 4'h0, '0);
    step("rel_all", 4'h0, 4'hF, '0);

    step("own_lock", 4'h1, 4'h0, id_at(0, 3));
    step("own_badul", 4'h0, 4'h1, id_at(0, 5));
    step("own_ul", 4'h0, 4'h1, id_at(0, 3));
    step("ul_free", 4'h0, 4'h1, id_at(0, 3));

    step("ct_lock", 4'h2, 4'h0, id_at(1, 2));
    step("ct_steal", 4'h2, 4'h0, id_at(1, 6));
    step("ct_lkul", 4'h2, 4'h2, id_at(1, 2));

    step("to_lock", 4'h4, 4'h0, id_at(2, 1));
    idle("to_idle", 18);

    step("rf_lock", 4'h4, 4'h0, id_at(2, 4));
    idle("rf_idle", 14);
    step("rf_ref", 4'h4, 4'h0, id_at(2, 4));
    idle("rf_hold", 17);
    step("rx_lock", 4'h4, 4'h0, id_at(2, 0));
    idle("rx_idle", 15);
    step("rx_ref", 4'h4, 4'h0, id_at(2, 0));
    idle("rx_hold", 3);
    step("rx_ul", 4'h0, 4'h4, id_at(2, 0));

    step("mr_lock", 4'h8, 4'h0, id_at(3, 7));
    idle("mr_idle", 6);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_clear();
    check("mr_locked", 32'(locked), 32'd0);
    check("mr_tevt", 32'(timeout_evt), 32'd0);
    check("mr_any", 32'(any_locked), 32'd0);
    check("mr_owner", 32'(owner), 32'd0);
    step("mr_hold", 4'h8, 4'h0, id_at(3, 7));
    rst = 1'b1;
    step("mr_relock", 4'h8, 4'h0, id_at(3, 7));
    step("mr_ul", 4'h0, 4'h8, id_at(3, 7));

    for (int k = 0; k < 400; k++) begin
      logic [NC-1:0]    lr;
      logic [NC-1:0]    ul;
      logic [NC*IW-1:0] ids;
      lr = NC'($urandom & $urandom & $urandom);
      ul = NC'($urandom & $urandom & $urandom);
      ids = '0;
      for (int c = 0; c < NC; c++) ids[c*IW +: IW] = IW'($urandom_range(0, 2));
      step("rnd", lr, ul, ids);
    end

    if (q.size() != 0) check("q_leftover", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lock_manager_mc.md
Name: lock_manager_mc

Overview:
- Parametrised multi-channel successor to the single-bit lock cell.
- Provides NUM_CH independent locks. Each lock records an owner ID, rejects lock and unlock attempts from non-owners, and releases itself automatically after a configurable hold timeout.
- Sits between software-visible requesters and shared resources. The existing lock/unlock property checks apply to each channel.

Parameters:
- NUM_CH, 4, number of independent lock channels.
- ID_W, 3, width of the requester/owner ID.
- TIMEOUT, 16, hold limit in cycles before auto-release; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT+1) (minimum 1), width of the hold counter; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- lock_req  input  NUM_CH  per-channel lock request, level, sampled each edge.
- unlock  input  NUM_CH  per-channel unlock request, level, sampled each edge.
- req_id  input  NUM_CH*ID_W  per-channel requester ID; channel i occupies bits [i*ID_W +: ID_W].
- locked  output  NUM_CH  per-channel lock state.
- owner  output  NUM_CH*ID_W  per-channel owner ID; 0 when unlocked.
- grant  output  NUM_CH  1-cycle pulse: lock acquired or refreshed.
- deny  output  NUM_CH  1-cycle pulse: request rejected.
- timeout_evt  output  NUM_CH  1-cycle pulse: auto-release occurred.
- any_locked  output  1  OR of locked; registered.

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, every counter is 0, every channel is in UNLOCKED. Deassertion is taken on the next clk edge.
- All outputs are registered. A request sampled at edge E is reflected in the outputs after E (1-cycle latency). Pulses last exactly one cycle.
- Channels are fully independent; the per-channel FSM has two states, UNLOCKED and LOCKED.
- UNLOCKED, lock_req=1 -> LOCKED; owner<=req_id; cnt<=0; grant=1. unlock is ignored when it arrives together with lock_req (lock wins).
- UNLOCKED, unlock=1, lock_req=0 -> stay UNLOCKED; deny=1.
- LOCKED, unlock=1, req_id==owner -> UNLOCKED; owner<=0; cnt<=0. No pulse. This takes priority over lock_req and over timeout.
- LOCKED, unlock=1, req_id!=owner -> deny=1; the unlock has no effect. lock_req in the same cycle is also rejected. Timeout still advances and may fire in this cycle.
- LOCKED, lock_req=1, unlock=0, req_id==owner -> refresh: cnt<=0; grant=1; the timeout is suppressed in this cycle.
- LOCKED, lock_req=1, unlock=0, req_id!=owner -> deny=1. The counter advances as normal.
- Timeout (TIMEOUT>0):
  - In LOCKED with no owner-unlock and no refresh, cnt increments every edge.
  - At the edge where cnt==TIMEOUT-1: go to UNLOCKED; owner<=0; cnt<=0; timeout_evt=1.
  - locked is therefore high for exactly TIMEOUT cycles after an unrefreshed grant.
  - If deny and timeout_evt coincide, both pulse.
- TIMEOUT=0: the counter is held at 0, timeout_evt stays 0, and the lock is held indefinitely.
- req_id=0 is a legal owner. owner==0 does not by itself indicate the unlocked state; use locked for that.
- any_locked is updated from the next-state values, so it matches the locked bits in the same cycle.
- Asserting reset mid-operation: all locks are released immediately. No timeout_evt is generated.

Test Plan:
- Reset: hold rst=0 for 3 cycles with lock_req=4'hF -> locked=0, owner=0, no pulses; after rst=1 and one edge -> locked=4'hF, grant=4'hF for 1 cycle.
- Ownership: ch0 lock with id 3 -> owner[2:0]=3. Unlock with id 5 -> deny[0]=1, locked[0] stays 1. Unlock with id 3 -> locked[0]=0 next cycle, owner=0.
- Contention: ch1 held by id 2; lock_req from id 6 -> deny[1]=1, owner stays 2. Simultaneous lock_req+unlock from id 2 -> released; no grant.
- Timeout (TIMEOUT=16): ch2 lock, then idle -> locked[2] high exactly 16 cycles; timeout_evt[2] pulses on the falling cycle.
- Refresh: owner re-requests at cycle 15 -> grant pulse, cnt=0, lock held a further 16 cycles, no timeout_evt. A refresh at the expiry edge suppresses the timeout.
- Reset mid-hold: rst=0 at cycle 7 of a hold on ch3 -> locked[3]=0 asynchronously, timeout_evt=0, any_locked=0.
